// File: rtl/dup_range_gen_pkg.sv
// Shared types and helpers for the dup_range_gen range/repeat generator.
package dup_range_gen_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DUP_W = 4;
  // Widest WIDTH supported by in_range; operands are sign-extended to MAX_W+1 bits.
  localparam int unsigned MAX_W     = 64;

  typedef enum logic [1:0] {
    DONE  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2
  } state_e;

  // step_sign=1 means a negative step: the range runs downward toward limit.
  function automatic logic in_range(input logic signed [MAX_W:0] value,
                                    input logic signed [MAX_W:0] limit,
                                    input logic                  step_sign);
    return step_sign ? (value > limit) : (value < limit);
  endfunction

endpackage

// File: rtl/range_stepper.sv
// Range counter for dup_range_gen: holds the WIDTH+1-bit value and reports whether
// the current and next values are in range and representable in WIDTH bits.
module range_stepper
  import dup_range_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic                    advance_i,
  input  logic signed [WIDTH-1:0] base_i,
  input  logic signed [WIDTH-1:0] limit_i,
  input  logic signed [WIDTH-1:0] step_i,
  output logic signed [WIDTH-1:0] cur_o,
  output logic signed [WIDTH-1:0] next_o,
  output logic                    cur_ok_o,
  output logic                    next_ok_o
);

  logic signed [WIDTH:0]   counter_q, counter_d, next_val;
  logic signed [WIDTH-1:0] limit_q, step_q;
  logic                    step_nz, next_fits;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter_q <= '0;
      limit_q   <= '0;
      step_q    <= '0;
    end else begin
      counter_q <= counter_d;
      if (load_i) begin
        limit_q <= limit_i;
        step_q  <= step_i;
      end
    end
  end

  always_comb begin
    counter_d = counter_q;
    if (load_i)         counter_d = (WIDTH+1)'(base_i);
    else if (advance_i) counter_d = next_val;
  end

  // Counter always holds a WIDTH-representable value when advanced, so one guard bit suffices.
  assign next_val  = counter_q + (WIDTH+1)'(step_q);
  assign next_fits = (next_val[WIDTH] == next_val[WIDTH-1]);
  assign step_nz   = (step_q != '0);

  assign cur_o     = counter_q[WIDTH-1:0];
  assign next_o    = next_val[WIDTH-1:0];
  assign cur_ok_o  = step_nz && in_range((MAX_W+1)'(counter_q), (MAX_W+1)'(limit_q),
                                         step_q[WIDTH-1]);
  assign next_ok_o = step_nz && next_fits &&
                     in_range((MAX_W+1)'(next_val), (MAX_W+1)'(limit_q), step_q[WIDTH-1]);

endmodule

// File: rtl/dup_range_gen.sv
// Emits each value of range(base, limit, step) dup times over a ready/valid stream.
// Optional `_count` transfer counter port when DUP_RANGE_GEN_COUNT_EN is defined.
module dup_range_gen
  import dup_range_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DUP_W = DEF_DUP_W
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic        [DUP_W-1:0] dup,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0,
  output logic        [DUP_W-1:0] _1
`ifdef DUP_RANGE_GEN_COUNT_EN
  ,
  output logic [31:0]             _count
`endif
);

  state_e                  state_q, state_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic signed [WIDTH-1:0] out0_q, out0_d;
  logic        [DUP_W-1:0] rep_q, rep_d;
  logic        [DUP_W-1:0] dup_q;
  logic signed [WIDTH-1:0] cur_val, next_val;
  logic                    cur_ok, next_ok;
  logic                    consume, last_rep, advance;

  range_stepper #(.WIDTH(WIDTH)) u_stepper (
    .clk_i    (_clock),
    .rst_i    (_reset),
    .load_i   (_start),
    .advance_i(advance),
    .base_i   (base),
    .limit_i  (limit),
    .step_i   (step),
    .cur_o    (cur_val),
    .next_o   (next_val),
    .cur_ok_o (cur_ok),
    .next_ok_o(next_ok)
  );

  assign consume  = (state_q == EMIT) && valid_q && _ready;
  assign last_rep = (rep_q == dup_q - DUP_W'(1));
  assign advance  = consume && last_rep && !_start;

  always_ff @(posedge _clock) begin
    if (_reset) state_q <= DONE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (_start) begin
      state_d = CHECK;
    end else begin
      case (state_q)
        DONE:    state_d = DONE;
        CHECK:   state_d = (cur_ok && dup_q != '0) ? EMIT : DONE;
        EMIT:    if (advance && !next_ok) state_d = DONE;
        default: state_d = DONE;
      endcase
    end
  end

  // The next range value is presented directly on the last-repeat transfer, avoiding a bubble.
  always_comb begin
    valid_d = valid_q;
    out0_d  = out0_q;
    rep_d   = rep_q;
    if (_start) begin
      valid_d = 1'b0;
      rep_d   = '0;
    end else if (state_q == EMIT) begin
      if (!valid_q) begin
        valid_d = 1'b1;
        out0_d  = cur_val;
      end else if (_ready) begin
        if (!last_rep) begin
          rep_d = rep_q + DUP_W'(1);
        end else begin
          rep_d = '0;
          if (next_ok) out0_d  = next_val;
          else         valid_d = 1'b0;
        end
      end
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      out0_q  <= '0;
      rep_q   <= '0;
      dup_q   <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      out0_q  <= out0_d;
      rep_q   <= rep_d;
      if (_start) dup_q <= dup;
    end
  end

  assign _valid = valid_q;
  assign _done  = done_q;
  assign _0     = out0_q;
  assign _1     = rep_q;

`ifdef DUP_RANGE_GEN_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge _clock) begin
    if (_reset || _start) count_q <= '0;
    else if (consume)     count_q <= count_q + 32'd1;
  end

  assign _count = count_q;
`endif

endmodule

// File: tb/tb_dup_range_gen.sv
// Directed self-checking bench for dup_range_gen (32-bit and 8-bit instances).
module tb_dup_range_gen;

  logic               clk = 1'b0;
  logic               rst, start, ready;
  logic signed [31:0] base, limit, step;
  logic        [3:0]  dup;
  logic               valid, done;
  logic signed [31:0] o0;
  logic        [3:0]  o1;

  logic              start8;
  logic signed [7:0] base8, limit8, step8;
  logic        [3:0] dup8;
  logic              valid8, done8;
  logic signed [7:0] o0_8;
  logic        [3:0] o1_8;

  int checks = 0;
  int errors = 0;

  logic signed [31:0] obs_v[$];
  logic        [3:0]  obs_r[$];

  always #5 clk = ~clk;

  dup_range_gen #(.WIDTH(32), .DUP_W(4)) dut (
    ._clock(clk), ._reset(rst), ._start(start), .base(base), .limit(limit), .step(step),
    .dup(dup), ._ready(ready), ._valid(valid), ._done(done), ._0(o0), ._1(o1)
  );

  dup_range_gen #(.WIDTH(8), .DUP_W(4)) dut8 (
    ._clock(clk), ._reset(rst), ._start(start8), .base(base8), .limit(limit8), .step(step8),
    .dup(dup8), ._ready(ready), ._valid(valid8), ._done(done8), ._0(o0_8), ._1(o1_8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run and records every transfer; toggle=1 drives ready with pattern 1,0,0,1.
  task automatic collect(input logic signed [31:0] b, input logic signed [31:0] l,
                         input logic signed [31:0] s, input logic [3:0] d, input int toggle,
                         output int first_idx, output int done_idx, output int stable_errs);
    logic [3:0]         pat;
    logic               hold;
    logic signed [31:0] pv;
    logic        [3:0]  pr;
    pat = 4'b1001;
    obs_v.delete();
    obs_r.delete();
    base = b; limit = l; step = s; dup = d;
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    first_idx = -1; done_idx = -1; stable_errs = 0;
    hold = 1'b0; pv = '0; pr = '0;
    for (int k = 0; k < 200; k++) begin
      if (hold && (!valid || o0 !== pv || o1 !== pr)) stable_errs++;
      if (valid && first_idx < 0) first_idx = k;
      if (done) begin
        done_idx = k;
        break;
      end
      ready = (toggle != 0) ? pat[k % 4] : 1'b1;
      if (valid && ready) begin
        obs_v.push_back(o0);
        obs_r.push_back(o1);
      end
      hold = valid && !ready;
      pv = o0;
      pr = o1;
      tick();
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; base = 32'sd3; limit = 32'sd9; step = 32'sd1; dup = 4'd1;
    tick();
    checks++;
    if (valid !== 1'b0 || done !== 1'b0 || o0 !== 32'sd0 || o1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b done=%0b _0=%0d _1=%0d, required 0 0 0 0",
               valid, done, o0, o1);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: done=%0b valid=%0b, required done=1 valid=0", done, valid);
    end
    tick();
    checks++;
    if (done8 !== 1'b1 || valid8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_done8: done=%0b valid=%0b, required done=1 valid=0", done8, valid8);
    end
  endtask

  task automatic test_main();
    int fi, di, se;
    collect(0, 10, 2, 4'd2, 0, fi, di, se);
    checks++;
    if (fi !== 2) begin
      errors++;
      $display("FAIL main_latency: first valid at %0d, required 2", fi);
    end
    checks++;
    if (di !== 12) begin
      errors++;
      $display("FAIL main_done: done at %0d, required 12", di);
    end
    checks++;
    if (obs_v.size() !== 10) begin
      errors++;
      $display("FAIL main_count: %0d transfers, required 10", obs_v.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (obs_v[i] !== (i / 2) * 2 || obs_r[i] !== 4'(i % 2)) begin
          errors++;
          $display("FAIL main_elem%0d: got %0d/%0d, required %0d/%0d",
                   i, obs_v[i], obs_r[i], (i / 2) * 2, i % 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int fi, di, se;
    collect(0, 10, 2, 4'd2, 1, fi, di, se);
    checks++;
    if (se !== 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable cycles, required 0", se);
    end
    checks++;
    if (di < 0) begin
      errors++;
      $display("FAIL bp_timeout: done never seen, required done");
    end
    checks++;
    if (obs_v.size() !== 10) begin
      errors++;
      $display("FAIL bp_count: %0d transfers, required 10", obs_v.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (obs_v[i] !== (i / 2) * 2 || obs_r[i] !== 4'(i % 2)) begin
          errors++;
          $display("FAIL bp_elem%0d: got %0d/%0d, required %0d/%0d",
                   i, obs_v[i], obs_r[i], (i / 2) * 2, i % 2);
        end
      end
    end
  endtask

  task automatic test_neg_step();
    int fi, di, se;
    int exp_v[4];
    exp_v = '{10, 7, 4, 1};
    collect(10, 0, -3, 4'd1, 0, fi, di, se);
    checks++;
    if (obs_v.size() !== 4 || di !== 6) begin
      errors++;
      $display("FAIL neg_count: %0d transfers done@%0d, required 4 done@6", obs_v.size(), di);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_v[i] !== exp_v[i] || obs_r[i] !== 4'd0) begin
          errors++;
          $display("FAIL neg_elem%0d: got %0d/%0d, required %0d/0", i, obs_v[i], obs_r[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_zero_outputs();
    int fi, di, se;
    collect(0, 10, 0, 4'd3, 0, fi, di, se);
    checks++;
    if (obs_v.size() !== 0 || fi !== -1 || di !== 1) begin
      errors++;
      $display("FAIL zero_step: %0d transfers first=%0d done@%0d, required 0 -1 1", obs_v.size(), fi, di);
    end
    collect(5, 5, 1, 4'd2, 0, fi, di, se);
    checks++;
    if (obs_v.size() !== 0 || fi !== -1 || di !== 1) begin
      errors++;
      $display("FAIL empty_range: %0d transfers first=%0d done@%0d, required 0 -1 1", obs_v.size(), fi, di);
    end
    collect(0, 10, 1, 4'd0, 0, fi, di, se);
    checks++;
    if (obs_v.size() !== 0 || fi !== -1 || di !== 1) begin
      errors++;
      $display("FAIL zero_dup: %0d transfers first=%0d done@%0d, required 0 -1 1", obs_v.size(), fi, di);
    end
  endtask

  task automatic test_overflow_w8();
    base8 = 8'sd120; limit8 = 8'sd127; step8 = 8'sd5; dup8 = 4'd1; ready = 1'b1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    checks++;
    if (valid8 !== 1'b1 || o0_8 !== 8'sd120) begin
      errors++;
      $display("FAIL w8_first: valid=%0b _0=%0d, required 1 120", valid8, o0_8);
    end
    tick();
    checks++;
    if (valid8 !== 1'b1 || o0_8 !== 8'sd125) begin
      errors++;
      $display("FAIL w8_second: valid=%0b _0=%0d, required 1 125", valid8, o0_8);
    end
    tick();
    checks++;
    if (valid8 !== 1'b0 || done8 !== 1'b1) begin
      errors++;
      $display("FAIL w8_end: valid=%0b done=%0b _0=%0d, required valid=0 done=1", valid8, done8, o0_8);
    end
  endtask

  task automatic test_reset_midstream();
    base = 0; limit = 100; step = 1; dup = 4'd2; ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (valid !== 1'b1 || o0 !== 32'sd1 || o1 !== 4'd1) begin
      errors++;
      $display("FAIL mid_before: valid=%0b _0=%0d _1=%0d, required 1 1 1", valid, o0, o1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%0b done=%0b, required 0 0", valid, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_done: done=%0b valid=%0b, required 1 0", done, valid);
    end
  endtask

  task automatic test_restart();
    int fi, di, se;
    base = 0; limit = 100; step = 1; dup = 4'd2; ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    collect(0, 4, 1, 4'd1, 0, fi, di, se);
    checks++;
    if (fi !== 2 || di !== 6 || obs_v.size() !== 4) begin
      errors++;
      $display("FAIL restart_shape: first=%0d done@%0d n=%0d, required 2 6 4", fi, di, obs_v.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_v[i] !== i || obs_r[i] !== 4'd0) begin
          errors++;
          $display("FAIL restart_elem%0d: got %0d/%0d, required %0d/0", i, obs_v[i], obs_r[i], i);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    base = '0; limit = '0; step = '0; dup = '0;
    start8 = 1'b0; base8 = '0; limit8 = '0; step8 = '0; dup8 = '0;
    tick();
    test_reset();
    test_main();
    test_backpressure();
    test_neg_step();
    test_zero_outputs();
    test_overflow_w8();
    test_reset_midstream();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
